// File: rtl/uart_param.sv
// uart_param: full-duplex UART with a runtime baud divisor and per-frame configuration.
// TX and RX run independent dividers that produce 16 oversample ticks per bit. The
// format is sampled when a frame starts, so changing the inputs mid-frame has no effect.
module uart_param #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             tx,
  input  logic             rx,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break,
  output logic             rx_busy,
  output logic             tx_busy
);

  localparam logic [4:0]       LAST_TICK  = 5'(OVS - 1);
  localparam logic [4:0]       LAST_TICK2 = 5'(2 * OVS - 1);
  localparam logic [4:0]       SAMP_A     = 5'(OVS / 2 - 1);
  localparam logic [4:0]       SAMP_B     = 5'(OVS / 2);
  localparam logic [4:0]       SAMP_C     = 5'(OVS / 2 + 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t        r_tx_state, w_tx_next;
  logic [DIV_W-1:0] r_tx_div, r_tx_div_cnt, w_tx_div_eff;
  logic [4:0]       r_tx_tick_cnt, w_tx_last;
  logic [2:0]       r_tx_bit_idx, r_tx_nbits_m1;
  logic [7:0]       r_tx_shift, w_tx_mask;
  logic             r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx_line;
  logic             w_tx_accept, w_tx_tick, w_tx_bit_end, w_tx_line;

  assign w_tx_mask    = 8'hFF >> (2'd3 - data_bits);
  assign w_tx_accept  = tx_valid && (r_tx_state == TX_IDLE);
  assign w_tx_div_eff = (r_tx_div == '0) ? DIV_ONE : r_tx_div;
  assign w_tx_tick    = (r_tx_state != TX_IDLE) && (r_tx_div_cnt == w_tx_div_eff - DIV_ONE);
  assign w_tx_last    = (r_tx_state == TX_STOP && r_tx_stop2) ? LAST_TICK2 : LAST_TICK;
  assign w_tx_bit_end = w_tx_tick && (r_tx_tick_cnt == w_tx_last);

  // TX next-state and next line level; the line is registered so tx never glitches.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_tx_next = r_tx_state;
    w_tx_line = 1'b1;
    case (r_tx_state)
      TX_IDLE:   if (tx_valid) w_tx_next = TX_START;
      TX_START:  if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA:   if (w_tx_bit_end && r_tx_bit_idx == r_tx_nbits_m1)
                   w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
      TX_STOP:   if (w_tx_bit_end) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
    case (w_tx_next)
      TX_START:  w_tx_line = 1'b0;
      TX_DATA:   w_tx_line = (r_tx_state == TX_DATA && w_tx_bit_end) ? r_tx_shift[1] : r_tx_shift[0];
      TX_PARITY: w_tx_line = r_tx_par_bit;
      default:   w_tx_line = 1'b1;
    endcase
  end

  // TX state register, frame config capture, divider, tick and bit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state    <= TX_IDLE;
      r_tx_line     <= 1'b1;
      r_tx_div      <= '0;
      r_tx_div_cnt  <= '0;
      r_tx_tick_cnt <= '0;
      r_tx_bit_idx  <= '0;
      r_tx_nbits_m1 <= '0;
      r_tx_shift    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_stop2    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      r_tx_state <= w_tx_next;
      r_tx_line  <= w_tx_line;
      if (w_tx_accept) begin
        r_tx_div      <= baud_div;
        r_tx_div_cnt  <= '0;
        r_tx_tick_cnt <= '0;
        r_tx_bit_idx  <= '0;
        r_tx_nbits_m1 <= {1'b1, data_bits};
        r_tx_shift    <= tx_data & w_tx_mask;
        r_tx_par_en   <= ^parity_mode;
        r_tx_par_bit  <= (^(tx_data & w_tx_mask)) ^ (parity_mode == 2'b10);
        r_tx_stop2    <= stop2;
      end else if (r_tx_state != TX_IDLE) begin
        r_tx_div_cnt <= w_tx_tick ? '0 : r_tx_div_cnt + DIV_ONE;
        if (w_tx_bit_end) begin
          r_tx_tick_cnt <= '0;
          if (r_tx_state == TX_DATA) begin
            r_tx_shift   <= r_tx_shift >> 1;
            r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
          end
        end else if (w_tx_tick) begin
          r_tx_tick_cnt <= r_tx_tick_cnt + 5'd1;
        end
      end
    end
  end

  assign tx       = r_tx_line;
  assign tx_ready = (r_tx_state == TX_IDLE);
  assign tx_busy  = (r_tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_t        r_rx_state, w_rx_next;
  logic             r_rx_s1, r_rx_s2;
  logic [DIV_W-1:0] r_rx_div, r_rx_div_cnt, w_rx_div_eff;
  logic [4:0]       r_rx_tick_cnt;
  logic [2:0]       r_rx_bit_idx, r_rx_nbits_m1;
  logic [7:0]       r_rx_shift, r_rx_data;
  logic [1:0]       r_rx_samp;
  logic             r_rx_par_en, r_rx_odd, r_rx_par_bit, r_rx_all_zero;
  logic             r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_brk;
  logic             w_rx_active, w_rx_start, w_rx_tick, w_rx_decide, w_rx_bit_end, w_rx_maj;

  assign w_rx_active  = (r_rx_state != RX_IDLE) && (r_rx_state != RX_WAIT_IDLE);
  assign w_rx_start   = (r_rx_state == RX_IDLE) && !r_rx_s2;
  assign w_rx_div_eff = (r_rx_div == '0) ? DIV_ONE : r_rx_div;
  assign w_rx_tick    = w_rx_active && (r_rx_div_cnt == w_rx_div_eff - DIV_ONE);
  assign w_rx_decide  = w_rx_tick && (r_rx_tick_cnt == SAMP_C);
  assign w_rx_bit_end = w_rx_tick && (r_rx_tick_cnt == LAST_TICK);
  // 2-of-3 vote over the two stored mid-bit samples and the current one.
  assign w_rx_maj     = (r_rx_samp[0] & r_rx_samp[1]) | (r_rx_samp[0] & r_rx_s2) | (r_rx_samp[1] & r_rx_s2);

  // RX next-state: bits are judged at the third mid-bit sample, advanced at the bit's last tick.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:      if (!r_rx_s2) w_rx_next = RX_START;
      RX_START:     if (w_rx_decide && w_rx_maj) w_rx_next = RX_IDLE;
                    else if (w_rx_bit_end) w_rx_next = RX_DATA;
      RX_DATA:      if (w_rx_bit_end && r_rx_bit_idx == r_rx_nbits_m1)
                      w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (w_rx_bit_end) w_rx_next = RX_STOP;
      RX_STOP:      if (w_rx_decide) w_rx_next = w_rx_maj ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (r_rx_s2) w_rx_next = RX_IDLE;
      default:      w_rx_next = RX_IDLE;
    endcase
  end

  // RX synchroniser, state register, sampling datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1       <= 1'b1;
      r_rx_s2       <= 1'b1;
      r_rx_state    <= RX_IDLE;
      r_rx_div      <= '0;
      r_rx_div_cnt  <= '0;
      r_rx_tick_cnt <= '0;
      r_rx_bit_idx  <= '0;
      r_rx_nbits_m1 <= '0;
      r_rx_shift    <= '0;
      r_rx_samp     <= '0;
      r_rx_par_en   <= 1'b0;
      r_rx_odd      <= 1'b0;
      r_rx_par_bit  <= 1'b0;
      r_rx_all_zero <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_perr     <= 1'b0;
      r_rx_ferr     <= 1'b0;
      r_rx_brk      <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      if (w_rx_start) begin
        r_rx_div      <= baud_div;
        r_rx_div_cnt  <= '0;
        r_rx_tick_cnt <= '0;
        r_rx_bit_idx  <= '0;
        r_rx_nbits_m1 <= {1'b1, data_bits};
        r_rx_shift    <= '0;
        r_rx_par_en   <= ^parity_mode;
        r_rx_odd      <= (parity_mode == 2'b10);
        r_rx_all_zero <= 1'b1;
      end else if (w_rx_active) begin
        r_rx_div_cnt <= w_rx_tick ? '0 : r_rx_div_cnt + DIV_ONE;
        if (w_rx_bit_end)   r_rx_tick_cnt <= '0;
        else if (w_rx_tick) r_rx_tick_cnt <= r_rx_tick_cnt + 5'd1;
        if (w_rx_tick && r_rx_tick_cnt == SAMP_A) r_rx_samp[0] <= r_rx_s2;
        if (w_rx_tick && r_rx_tick_cnt == SAMP_B) r_rx_samp[1] <= r_rx_s2;
        if (w_rx_bit_end && r_rx_state == RX_DATA) r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
        if (w_rx_decide) begin
          case (r_rx_state)
            RX_DATA: begin
              r_rx_shift[r_rx_bit_idx] <= w_rx_maj;
              r_rx_all_zero            <= r_rx_all_zero & ~w_rx_maj;
            end
            RX_PARITY: begin
              r_rx_par_bit  <= w_rx_maj;
              r_rx_all_zero <= r_rx_all_zero & ~w_rx_maj;
            end
            RX_STOP: begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx_shift;
              r_rx_perr  <= r_rx_par_en & ((^r_rx_shift) ^ r_rx_par_bit ^ r_rx_odd);
              r_rx_ferr  <= ~w_rx_maj;
              r_rx_brk   <= r_rx_all_zero & ~w_rx_maj;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_break      = r_rx_brk;
  assign rx_busy       = (r_rx_state != RX_IDLE);

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 DIV_W, default 16: width of the runtime baud divisor.
REQ-002 OVS, default 16: oversampling ticks per bit; fixed at 16 in this revision, other values unsupported.
REQ-003 clk  input  1  master clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 baud_div  input  DIV_W  clocks per oversample tick; 0 treated as 1.
REQ-006 data_bits  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
REQ-007 parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-008 stop2  input  1  1=two stop bits on TX; 0=one.
REQ-009 tx_valid  input  1  byte offered for transmission.
REQ-010 tx_data  input  8  byte to transmit; bits above data length ignored.
REQ-011 tx_ready  output  1  transmitter idle; accepts on tx_valid&&tx_ready.
REQ-012 tx  output  1  serial output; idle high.
REQ-013 rx  input  1  asynchronous serial input.
REQ-014 rx_valid  output  1  one-cycle pulse: frame complete, rx_data/error flags valid.
REQ-015 rx_data  output  8  received data, LSB first on line; unused MSBs zero.
REQ-016 rx_parity_err, rx_frame_err, rx_break  output  1 each  status qualified by rx_valid.
REQ-017 rx_busy, tx_busy  output  1 each  high whenever RX/TX state is not IDLE.

Function
REQ-018 Independent TX and RX tick dividers; tick every max(baud_div,1) clocks; each divider restarts at frame start.
REQ-019 rx passes a 2-flop synchroniser before any use (2-cycle input latency).
REQ-020 Config inputs (baud_div, data_bits, parity_mode, stop2) latched per frame: TX at accept, RX at start detect; mid-frame changes have no effect.
REQ-021 TX states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly 16 ticks.
REQ-022 On accept, tx drives 0 from the next cycle; tx_ready low from the next cycle.
REQ-023 Data LSB first; PARITY state skipped when parity none; even parity = XOR of sent data bits, odd = its inverse.
REQ-024 STOP lasts 16 ticks (stop2=0) or 32 ticks (stop2=1) with tx=1; tx_ready high the cycle after STOP ends; back-to-back accept then possible with no idle gap.
REQ-025 RX states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-026 IDLE: synchronised rx low -> START, tick count 0.
REQ-027 Each bit sampled at ticks 7, 8, 9; bit value = 2-of-3 majority.
REQ-028 START majority 1 -> false start, return to IDLE, no rx_valid, no error.
REQ-029 RX checks one stop bit regardless of stop2; stop majority 0 -> rx_frame_err.
REQ-030 Parity mismatch -> rx_parity_err; flag 0 when parity none.
REQ-031 Break: all data bits, parity bit (if enabled) and stop bit sampled 0 -> rx_break=1 and rx_frame_err=1, rx_data=0.
REQ-032 rx_valid pulses one cycle after the stop-bit tick-9 sample; outputs hold until next rx_valid.
REQ-033 After frame_err, RX enters WAIT_IDLE until synchronised rx is 1, then IDLE; otherwise IDLE directly after stop sample.
REQ-034 rx_valid is not back-pressured; a frame completing while the previous data is unread overwrites it.

Reset
REQ-035 rst_n low asynchronously forces: both FSMs IDLE, dividers 0, tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, busy flags 0, synchroniser flops 1.
REQ-036 Reset mid-frame aborts immediately; tx returns high without completing the frame; the first frame after release is received from a clean start bit.

Verification
REQ-037 baud_div=4, 8N1, send 0xA5 -> tx low 64 clocks, bits 1,0,1,0,0,1,0,1 at 64 clocks each, high 64; tx_ready returns at clock 640 after accept.
REQ-038 Loopback tx->rx, 7E2, data 0x5A -> rx_valid once, rx_data=0x5A, all errors 0; TX frame 11 bits long.
REQ-039 RX 8O1 with wrong parity bit injected -> rx_valid, rx_parity_err=1, rx_frame_err=0.
REQ-040 rx low 2 ticks then high (glitch) -> no rx_valid, RX back to IDLE; single-tick glitch at sample tick 8 of a data bit -> majority corrects, data intact.
REQ-041 rx held low 20 bit times, 8N1 -> rx_valid with rx_break=1, rx_frame_err=1, rx_data=0x00; no further rx_valid until rx returns high and a new start bit arrives.
REQ-042 rst_n asserted mid-TX data bit and mid-RX frame -> tx=1, tx_ready=1 same cycle (async), no rx_valid; subsequent 8N1 frame 0x3C received correctly.
